// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Buffer entries carry the byte PC alongside the fetched word.
`ifndef FETCH_UNIT_PKG_SV
`define FETCH_UNIT_PKG_SV
package fetch_unit_pkg;

    localparam logic [31:0] INST_NOP   = 32'h0000_0013;
    localparam int          WORD_SHIFT = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    localparam fetch_entry_t ENTRY_RESET = '{pc: 32'h0, inst: INST_NOP};

endpackage
`endif

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of {pc, inst} between the memory response and decode.
// Flush wins over push and pop; push and pop may coincide at any fill level.
`ifndef FETCH_BUFFER_SV
`define FETCH_BUFFER_SV
module fetch_buffer
    import fetch_unit_pkg::*;
(
    input  logic         clock,
    input  logic         reset_n,
    input  logic         push,
    input  fetch_entry_t data,
    input  logic         pop,
    input  logic         flush,
    output logic [1:0]   count,
    output fetch_entry_t head
);

    fetch_entry_t slot [2];
    logic         rd_ptr;
    logic         wr_ptr;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            slot[0] <= ENTRY_RESET;
            slot[1] <= ENTRY_RESET;
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            count   <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                slot[wr_ptr] <= data;
                wr_ptr       <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head = slot[rd_ptr];

endmodule
`endif

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, tags the one-cycle memory response and
// feeds decode through a 2-entry buffer with credit-based issue.
`ifndef FETCH_UNIT_SV
`define FETCH_UNIT_SV
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic [31:0] inst_ain,
    input  logic [31:0] inst_dout,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst
);

    logic [31:0]  pc;
    logic [31:0]  rsp_pc;
    logic         rsp_valid;
    logic [1:0]   count;
    logic         pop;
    logic         issue;
    logic [2:0]   credit_used;
    logic [2:0]   credit_limit;
    fetch_entry_t head;
    fetch_entry_t rsp_entry;

    assign out_valid = (count != 2'd0);
    assign pop       = out_valid && out_ready;

    // In-flight response counts against capacity; a pop frees a slot now.
    assign credit_used  = {1'b0, count} + {2'b00, rsp_valid};
    assign credit_limit = 3'd2 + {2'b00, pop};
    assign issue        = !redirect_valid && (credit_used < credit_limit);

    assign inst_ain = pc >> WORD_SHIFT;

    assign rsp_entry = '{pc: rsp_pc, inst: inst_dout};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc        <= RESET_PC;
            rsp_pc    <= 32'h0;
            rsp_valid <= 1'b0;
        end else if (redirect_valid) begin
            pc        <= redirect_pc & ~32'h3;
            rsp_valid <= 1'b0;
        end else begin
            rsp_valid <= issue;
            if (issue) begin
                rsp_pc <= pc;
                pc     <= pc + 32'd4;
            end
        end
    end

    fetch_buffer u_buffer (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (rsp_valid),
        .data    (rsp_entry),
        .pop     (pop),
        .flush   (redirect_valid),
        .count   (count),
        .head    (head)
    );

    assign out_pc   = out_valid ? head.pc   : 32'h0;
    assign out_inst = out_valid ? head.inst : 32'h0;

endmodule
`endif

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: free run, stall, redirects, wrap
// and asynchronous reset, against a word-indexed memory model.
module tb_fetch_unit;

    logic        clock;
    logic        reset_n;
    logic [31:0] inst_ain;
    logic [31:0] inst_dout;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;

    int          checks;
    int          failures;
    logic [31:0] exp_pc;
    logic [31:0] held_pc;
    logic [31:0] held_ain;

    fetch_unit #(.RESET_PC(32'h0)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .inst_ain       (inst_ain),
        .inst_dout      (inst_dout),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] word_addr);
        return 32'h100 + word_addr;
    endfunction

    always @(posedge clock) inst_dout <= mem_word(inst_ain);

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Head is consumed at the next edge: check it against the model.
    task automatic expect_pop(input string tag);
        chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        chk({tag, "_pc"}, out_pc, exp_pc);
        chk({tag, "_inst"}, out_inst, mem_word(exp_pc >> 2));
        exp_pc = exp_pc + 32'd4;
    endtask

    task automatic redirect_to(input logic [31:0] target,
                               input logic [31:0] exp_ain, input string tag);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        step();
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        chk({tag, "_n1_valid"}, {31'b0, out_valid}, 32'd0);
        chk({tag, "_n1_ain"}, inst_ain, exp_ain);
        step();
        chk({tag, "_n2_valid"}, {31'b0, out_valid}, 32'd0);
        step();
        exp_pc = target & ~32'h3;
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        reset_n        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b1;
        repeat (3) step();
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_pc", out_pc, 32'h0);
        chk("rst_inst", out_inst, 32'h0);
        chk("rst_ain", inst_ain, 32'h0);

        reset_n = 1'b1;
        chk("c0_valid", {31'b0, out_valid}, 32'd0);
        step();
        chk("c1_valid", {31'b0, out_valid}, 32'd0);
        step();
        exp_pc = 32'h0;
        for (int i = 0; i < 6; i++) begin
            expect_pop("run");
            step();
        end

        out_ready = 1'b0;
        held_pc   = exp_pc;
        step();
        held_ain = inst_ain;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stall_count", {30'b0, dut.count}, 32'd2);
            chk("stall_ain", inst_ain, held_ain);
            chk("stall_pc", out_pc, held_pc);
            chk("stall_inst", out_inst, mem_word(held_pc >> 2));
        end
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            expect_pop("release");
            step();
        end

        out_ready = 1'b0;
        step();
        step();
        redirect_to(32'h40, 32'h10, "redir_full");
        for (int i = 0; i < 3; i++) begin
            expect_pop("redir_full");
            step();
        end

        out_ready = 1'b0;
        redirect_to(32'h43, 32'h10, "redir_43");
        for (int i = 0; i < 3; i++) begin
            expect_pop("redir_43");
            step();
        end

        expect_pop("redir_pop_head");
        redirect_to(32'h80, 32'h20, "redir_pop");
        for (int i = 0; i < 3; i++) begin
            expect_pop("redir_pop");
            step();
        end

        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        chk("wrap_ain0", inst_ain, 32'h3FFF_FFFF);
        step();
        chk("wrap_ain1", inst_ain, 32'h0);
        step();
        exp_pc = 32'hFFFF_FFFC;
        for (int i = 0; i < 3; i++) begin
            expect_pop("wrap");
            step();
        end

        out_ready = 1'b0;
        step();
        step();
        chk("pre_rst_count", {30'b0, dut.count}, 32'd2);
        reset_n = 1'b0;
        #2;
        chk("async_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("async_rst_ain", inst_ain, 32'h0);
        #1;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        step();
        chk("rst2_c1_valid", {31'b0, out_valid}, 32'd0);
        step();
        exp_pc = 32'h0;
        for (int i = 0; i < 4; i++) begin
            expect_pop("rst2");
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
